// File: rtl/phj_hash_pkg.sv
// ---------------------------------------------------------------------------
// phj_hash_pkg
// Shared constants and types for the tuple hash stage.
//   FMIX_C1/FMIX_C2 : Murmur3 fmix32 multipliers
//   HASH_LATENCY    : register stages between tuple acceptance and out_valid
//   tag_t           : 32-bit hash tag
//   serial_t        : 64-bit per-lane serial number
// Optional build macro TUPLE_HASHER_IDENTITY_EN (used in fmix32_pipe) turns
// the hash into a zero-extended key pass-through.
// ---------------------------------------------------------------------------
package phj_hash_pkg;

    localparam logic [31:0] FMIX_C1      = 32'h85EBCA6B;
    localparam logic [31:0] FMIX_C2      = 32'hC2B2AE35;
    localparam int          HASH_LATENCY = 3;

    typedef logic [31:0] tag_t;
    typedef logic [63:0] serial_t;

    // k ^ (k >> sh): the xor-shift step used by every fmix32 round
    function automatic tag_t xorshift(input tag_t k, input int unsigned sh);
        return k ^ (k >> sh);
    endfunction

endpackage

// File: rtl/fmix32_pipe.sv
// ---------------------------------------------------------------------------
// fmix32_pipe
// Three-register Murmur3 fmix32 datapath. Each stage register loads when its
// enable is high, so the owner of the handshake decides when data advances.
//   clk, reset : clock, synchronous active-high reset (clears all stages)
//   en1..en3   : load enables for stage 1..3
//   key        : 32-bit key entering stage 1
//   tag        : stage 3 result
// Build macro TUPLE_HASHER_IDENTITY_EN: when defined the stages only carry the
// key through unchanged (tag = key), keeping the same three-cycle timing.
// ---------------------------------------------------------------------------
module fmix32_pipe
    import phj_hash_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic en1,
    input  logic en2,
    input  logic en3,
    input  tag_t key,
    output tag_t tag
);

    tag_t h1, h2, h3;
    tag_t nxt1, nxt2, nxt3;

`ifdef TUPLE_HASHER_IDENTITY_EN
    assign nxt1 = key;
    assign nxt2 = h1;
    assign nxt3 = h2;
`else
    // All products are truncated to 32 bits, i.e. mod 2^32
    assign nxt1 = xorshift(key, 16) * FMIX_C1;
    assign nxt2 = xorshift(h1, 13) * FMIX_C2;
    assign nxt3 = xorshift(h2, 16);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            h1 <= '0;
            h2 <= '0;
            h3 <= '0;
        end else begin
            if (en1) h1 <= nxt1;
            if (en2) h2 <= nxt2;
            if (en3) h3 <= nxt3;
        end
    end

    assign tag = h3;

endmodule

// File: rtl/tuple_hasher.sv
// ---------------------------------------------------------------------------
// tuple_hasher
// Single-lane hash stage: tags each tuple with fmix32(key), stamps a per-lane
// serial number and forwards the last/joined flags, three cycles deep,
// one tuple per cycle.
// Parameters:
//   INPUT_SIZE  : tuple width; key is in_data[KEY_BITS-1:0]
//   KEY_BITS    : key width (1..32), zero-extended to 32 before hashing
//   SERIAL_BASE : start / reload value of the serial counter
// Ports:
//   clk, reset                   : clock, synchronous active-high reset
//   in_data/in_valid/in_ready    : tuple input handshake
//   in_last, in_was_joined       : sideband flags qualified by in_valid
//   out_data/out_tag/out_valid/out_ready : output lane handshake
//   out_last_processed, out_serialnum, out_was_joined : sidebands
// Build macro TUPLE_HASHER_IDENTITY_EN: out_tag = zero-extended key.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. Producers hold valid and payload until that edge; out_* are
// held stable while out_valid && !out_ready. in_ready depends
// combinationally on out_ready, never on in_valid.
// ---------------------------------------------------------------------------
module tuple_hasher
    import phj_hash_pkg::*;
#(
    parameter int      INPUT_SIZE  = 64,
    parameter int      KEY_BITS    = 32,
    parameter serial_t SERIAL_BASE = 64'd0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [INPUT_SIZE-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic                  in_was_joined,
    output logic [INPUT_SIZE-1:0] out_data,
    output tag_t                  out_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last_processed,
    output serial_t               out_serialnum,
    output logic                  out_was_joined
);

    // Stage valids and payloads; index = stage number
    logic                  v1, v2, v3;
    logic [INPUT_SIZE-1:0] d1, d2, d3;
    logic                  l1, l2, l3;
    logic                  j1, j2, j3;
    serial_t               s1, s2, s3;
    serial_t               cnt;

    logic en1, en2, en3;
    logic accept;
    tag_t key;

    // A stage loads when it is empty or the stage after it is taking its
    // contents this cycle; bubbles therefore collapse as the chain moves.
    assign en3      = !v3 || out_ready;
    assign en2      = !v2 || en3;
    assign en1      = !v1 || en2;
    assign in_ready = en1;
    assign accept   = in_valid && in_ready;

    assign key = tag_t'(in_data[KEY_BITS-1:0]);

    fmix32_pipe u_fmix (
        .clk   (clk),
        .reset (reset),
        .en1   (en1),
        .en2   (en2),
        .en3   (en3),
        .key   (key),
        .tag   (out_tag)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            v1  <= 1'b0;
            v2  <= 1'b0;
            v3  <= 1'b0;
            d1  <= '0;
            d2  <= '0;
            d3  <= '0;
            l1  <= 1'b0;
            l2  <= 1'b0;
            l3  <= 1'b0;
            j1  <= 1'b0;
            j2  <= 1'b0;
            j3  <= 1'b0;
            s1  <= '0;
            s2  <= '0;
            s3  <= '0;
            cnt <= SERIAL_BASE;
        end else begin
            if (en1) begin
                v1 <= in_valid;
                d1 <= in_data;
                l1 <= in_last && in_valid;
                j1 <= in_was_joined;
                s1 <= cnt;
            end
            if (en2) begin
                v2 <= v1;
                d2 <= d1;
                l2 <= l1;
                j2 <= j1;
                s2 <= s1;
            end
            if (en3) begin
                v3 <= v2;
                d3 <= d2;
                l3 <= l2;
                j3 <= j2;
                s3 <= s2;
            end
            // The last tuple of a relation keeps the current value; the
            // next relation starts again from the base. Plain 64-bit wrap.
            if (accept) begin
                cnt <= in_last ? SERIAL_BASE : cnt + 64'd1;
            end
        end
    end

    assign out_valid          = v3;
    assign out_data           = d3;
    assign out_last_processed = l3;
    assign out_was_joined     = j3;
    assign out_serialnum      = s3;

endmodule

// File: tb/tb_tuple_hasher.sv
module tb_tuple_hasher;
  import phj_hash_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT (base 0) ----------------
  logic [63:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_last = 1'b0;
  logic        in_was_joined = 1'b0;
  logic [63:0] out_data;
  logic [31:0] out_tag;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_last_processed;
  logic [63:0] out_serialnum;
  logic        out_was_joined;

  tuple_hasher #(.INPUT_SIZE(64), .KEY_BITS(32), .SERIAL_BASE(64'd0)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_was_joined(in_was_joined),
    .out_data(out_data), .out_tag(out_tag), .out_valid(out_valid),
    .out_ready(out_ready), .out_last_processed(out_last_processed),
    .out_serialnum(out_serialnum), .out_was_joined(out_was_joined)
  );

  // ---------------- DUT (base near wrap) ----------------
  logic [63:0] w_data = '0;
  logic        w_valid = 1'b0;
  logic        w_ready;
  logic [63:0] w_odata;
  logic [31:0] w_otag;
  logic        w_ovalid;
  logic        w_olast;
  logic [63:0] w_oser;
  logic        w_ojoined;

  tuple_hasher #(.INPUT_SIZE(64), .KEY_BITS(32), .SERIAL_BASE(64'hFFFF_FFFF_FFFF_FFFE)) dut_w (
    .clk(clk), .reset(reset),
    .in_data(w_data), .in_valid(w_valid), .in_ready(w_ready),
    .in_last(1'b0), .in_was_joined(1'b1),
    .out_data(w_odata), .out_tag(w_otag), .out_valid(w_ovalid),
    .out_ready(1'b1), .out_last_processed(w_olast),
    .out_serialnum(w_oser), .out_was_joined(w_ojoined)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic lat_en = 1'b0;
  logic [161:0] exp_q[$];   // {tag, serial, last, joined, data}
  int acc_q[$];
  logic [31:0] e_tag = '0;
  logic [63:0] e_ser = '0;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Reference fmix32, or the identity tag in the debug build
  function automatic logic [31:0] model_tag(input logic [63:0] d);
    logic [31:0] k;
    k = d[31:0];
`ifndef TUPLE_HASHER_IDENTITY_EN
    k = k ^ (k >> 16);
    k = k * 32'h85EBCA6B;
    k = k ^ (k >> 13);
    k = k * 32'hC2B2AE35;
    k = k ^ (k >> 16);
`endif
    return k;
  endfunction

  // Hand-computed tag for the directed keys, or the key in the debug build
  function automatic logic [31:0] known_tag(input logic [63:0] d, input logic [31:0] fm);
`ifdef TUPLE_HASHER_IDENTITY_EN
    return d[31:0];
`else
    return fm;
`endif
  endfunction

  logic        hold = 1'b0;
  logic [63:0] p_data = '0;
  logic [31:0] p_tag = '0;
  logic [63:0] p_ser = '0;
  logic        p_last = 1'b0;
  logic        p_joined = 1'b0;

  always @(negedge clk) begin
    logic [161:0] ent;
    int a;
    if (!reset) begin
      if (in_valid && in_ready) begin
        exp_q.push_back({e_tag, e_ser, in_last, in_was_joined, in_data});
        acc_q.push_back(cyc);
      end
      if (hold) begin
        check("hold_data", out_data, p_data);
        check("hold_tag", 64'(out_tag), 64'(p_tag));
        check("hold_serial", out_serialnum, p_ser);
        check("hold_last", 64'(out_last_processed), 64'(p_last));
        check("hold_joined", 64'(out_was_joined), 64'(p_joined));
        check("hold_valid", 64'(out_valid), 64'd1);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 64'(out_valid), 64'd0);
        end else begin
          ent = exp_q.pop_front();
          a = acc_q.pop_front();
          check("out_tag", 64'(out_tag), 64'(ent[161:130]));
          check("out_serial", out_serialnum, ent[129:66]);
          check("out_last", 64'(out_last_processed), 64'(ent[65]));
          check("out_joined", 64'(out_was_joined), 64'(ent[64]));
          check("out_data", out_data, ent[63:0]);
          if (lat_en) check("latency", 64'(cyc - a), 64'd3);
        end
      end
      hold = out_valid && !out_ready;
      p_data = out_data;
      p_tag = out_tag;
      p_ser = out_serialnum;
      p_last = out_last_processed;
      p_joined = out_was_joined;
    end else begin
      hold = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [63:0] d, input logic l, input logic j,
                      input logic [31:0] et, input logic [63:0] es);
    int n;
    logic done;
    n = 0;
    done = 1'b0;
    in_data = d;
    in_last = l;
    in_was_joined = j;
    e_tag = et;
    e_ser = es;
    in_valid = 1'b1;
    while (!done && n < 200) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    check("send_accept", 64'(done), 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      idle(1);
      n++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    acc_q.delete();
    idle(2);
    reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_out_serial", out_serialnum, 64'd0);
    check("rst_out_flags", 64'({out_last_processed, out_was_joined}), 64'd0);
    check("rst_w_out_valid", 64'(w_ovalid), 64'd0);
    @(posedge clk);
    #1;
  endtask

  logic [63:0] wkey [3];
  logic [31:0] wtag [3];
  logic [63:0] wser [3];

  // ---------------- directed sequence ----------------
  initial begin
    logic [63:0] d;

    do_reset();

    // Known keys, latency 3, serials 0..2; upper data bits must not matter
    lat_en = 1'b1;
    out_ready = 1'b1;
    d = 64'h1234_5678_0000_0000;
    send(d, 1'b0, 1'b0, known_tag(d, 32'h0000_0000), 64'd0);
    d = 64'hDEAD_BEEF_0000_0001;
    send(d, 1'b0, 1'b1, known_tag(d, 32'h514E_28B7), 64'd1);
    d = 64'h0000_0000_FFFF_FFFF;
    send(d, 1'b0, 1'b0, known_tag(d, 32'h81F1_6F39), 64'd2);
    drain();

    // Ten back-to-back tuples: latency 3 on each implies no output bubbles
    do_reset();
    for (int i = 0; i < 10; i++) begin
      d = {32'hC0DE_0000 | 32'(i), 32'h9E37_79B9 * 32'(i + 1)};
      send(d, 1'b0, 1'(i), model_tag(d), 64'(i));
    end
    drain();

    // Stall: exactly three held, outputs stable, then release without loss
    do_reset();
    lat_en = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d = 64'hAAAA_0000_5555_0000 + 64'(i * 7);
      send(d, 1'b0, 1'b0, model_tag(d), 64'(i));
    end
    d = 64'hAAAA_0000_5555_0100;
    in_data = d;
    in_valid = 1'b1;
    idle(4);
    @(negedge clk);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    check("stall_out_valid", 64'(out_valid), 64'd1);
    check("stall_held_count", 64'(exp_q.size()), 64'd3);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(d, 1'b0, 1'b1, model_tag(d), 64'd3);
    d = 64'h0F0F_0F0F_F0F0_F0F0;
    send(d, 1'b0, 1'b0, model_tag(d), 64'd4);
    drain();

    // End of relation at serial 4; counter restarts at the base
    do_reset();
    for (int i = 0; i < 7; i++) begin
      d = 64'h5000_0000_0000_0000 + 64'(i * 131);
      send(d, (i == 4), 1'b0, model_tag(d), (i < 5) ? 64'(i) : 64'(i - 5));
    end
    drain();

    // Serial wrap on the second instance: ...FFFE, ...FFFF, 0
    wkey[0] = 64'h0000_0000_0000_0000;
    wkey[1] = 64'h0000_0000_0000_0001;
    wkey[2] = 64'h0000_0000_FFFF_FFFF;
    wtag[0] = known_tag(wkey[0], 32'h0000_0000);
    wtag[1] = known_tag(wkey[1], 32'h514E_28B7);
    wtag[2] = known_tag(wkey[2], 32'h81F1_6F39);
    wser[0] = 64'hFFFF_FFFF_FFFF_FFFE;
    wser[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    wser[2] = 64'h0000_0000_0000_0000;
    for (int i = 0; i < 6; i++) begin
      if (i < 3) begin
        w_valid = 1'b1;
        w_data = wkey[i];
      end else begin
        w_valid = 1'b0;
      end
      @(negedge clk);
      if (i < 3) check("w_in_ready", 64'(w_ready), 64'd1);
      if (i >= 3) begin
        check("w_out_valid", 64'(w_ovalid), 64'd1);
        check("w_serial", w_oser, wser[i-3]);
        check("w_tag", 64'(w_otag), 64'(wtag[i-3]));
        check("w_data", w_odata, wkey[i-3]);
      end
      @(posedge clk);
      #1;
    end

    // Reset with two tuples in flight: they vanish, next tuple gets serial 0
    out_ready = 1'b1;
    d = 64'h7777_0000_0000_0077;
    send(d, 1'b0, 1'b0, model_tag(d), 64'd0);
    d = 64'h7777_0000_0000_0078;
    send(d, 1'b0, 1'b0, model_tag(d), 64'd1);
    do_reset();
    idle(6);
    d = 64'h1111_2222_3333_4444;
    send(d, 1'b0, 1'b1, model_tag(d), 64'd0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
